// File: rtl/adder_share_pkg.sv
// Shared types and constants for the adder-sharing sequencer.
package adder_share_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned SETTLE_MIN = 1;
    localparam int unsigned SETTLE_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Out-of-range settle values are clamped into the counter's legal range.
    function automatic int unsigned clamp_settle(input int unsigned v);
        if (v < SETTLE_MIN) return SETTLE_MIN;
        if (v > SETTLE_MAX) return SETTLE_MAX;
        return v;
    endfunction

endpackage

// File: rtl/Adder32.sv
// 32-bit ripple-carry adder datapath shared by the sequencer.
module Adder32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        CarryIn,
    output logic [31:0] RAdd,
    output logic        CarryOut
);

    logic carry;

    always_comb begin
        carry = CarryIn;
        RAdd  = '0;
        for (int i = 0; i < 32; i++) begin
            RAdd[i] = A[i] ^ B[i] ^ carry;
            carry   = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        CarryOut = carry;
    end

endmodule

// File: rtl/rr_picker.sv
// Round-robin picker: first asserted request at or above the pointer, with wrap.
module rr_picker #(
    parameter  int unsigned N   = 4,
    localparam int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] id_o,
    output logic           any_o
);

    int unsigned     pos;
    logic [IDW-1:0]  idx;

    always_comb begin
        gnt_o = '0;
        id_o  = '0;
        any_o = 1'b0;
        pos   = 0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = 32'(ptr_i) + k;
            if (pos >= N) pos = pos - N;
            idx = IDW'(pos);
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                id_o       = idx;
            end
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin sequencer sharing one Adder32 among NUM_REQ requesters.
// Define ADDER_SHARE_OVF_EN to add the registered signed-overflow output RespOvf.
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter  int unsigned NUM_REQ       = 4,
    parameter  int unsigned SETTLE_CYCLES = 2,
    localparam int unsigned IDW           = $clog2(NUM_REQ)
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        ReqValid,
    output logic [NUM_REQ-1:0]        ReqReady,
    input  logic [DATA_W*NUM_REQ-1:0] ReqDataA,
    input  logic [DATA_W*NUM_REQ-1:0] ReqDataB,
    output logic                      RespValid,
    input  logic                      RespReady,
    output logic [IDW-1:0]            RespId,
    output logic [DATA_W-1:0]         RespSum,
    output logic                      RespCarry
`ifdef ADDER_SHARE_OVF_EN
    ,
    output logic                      RespOvf
`endif
);

    localparam int unsigned SETTLE_EFF = clamp_settle(SETTLE_CYCLES);

    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q;
    logic [IDW-1:0]    id_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] opa_q, opb_q;
    logic [DATA_W-1:0] sum_q;
    logic              carry_q;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDW-1:0]     pick_id;
    logic               pick_any;
    logic               grant_c;
    logic               resp_fire_c;
    logic [DATA_W-1:0]  add_sum;
    logic               add_co;

    logic [DATA_W-1:0] a_arr [NUM_REQ];
    logic [DATA_W-1:0] b_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign a_arr[gi] = ReqDataA[gi*DATA_W +: DATA_W];
        assign b_arr[gi] = ReqDataB[gi*DATA_W +: DATA_W];
    end

    rr_picker #(.N(NUM_REQ)) u_picker (
        .req_i (ReqValid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .id_o  (pick_id),
        .any_o (pick_any)
    );

    // Operand registers hold the adder inputs stable for the whole settle window.
    Adder32 u_adder (
        .A        (opa_q),
        .B        (opb_q),
        .CarryIn  (1'b0),
        .RAdd     (add_sum),
        .CarryOut (add_co)
    );

    always_ff @(posedge Clock) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (pick_any) state_d = ST_SETTLE;
            ST_SETTLE: if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
            ST_RESP:   if (RespReady) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Grant is only offered while idle and out of reset.
    always_comb begin
        ReqReady    = '0;
        grant_c     = 1'b0;
        resp_fire_c = 1'b0;
        RespValid   = (state_q == ST_RESP);
        if (state_q == ST_IDLE && !Reset) begin
            ReqReady = pick_gnt;
            grant_c  = pick_any;
        end
        if (state_q == ST_RESP && RespReady) resp_fire_c = 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ptr_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            if (grant_c) begin
                opa_q <= a_arr[pick_id];
                opb_q <= b_arr[pick_id];
                id_q  <= pick_id;
                cnt_q <= CNT_W'(SETTLE_EFF);
            end
            if (state_q == ST_SETTLE) begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    sum_q   <= add_sum;
                    carry_q <= add_co;
                end
            end
            if (resp_fire_c) begin
                ptr_q <= (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + IDW'(1);
            end
        end
    end

`ifdef ADDER_SHARE_OVF_EN
    logic ovf_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ovf_q <= 1'b0;
        end else if (state_q == ST_SETTLE && cnt_q == CNT_W'(1)) begin
            ovf_q <= (opa_q[DATA_W-1] == opb_q[DATA_W-1]) &&
                     (add_sum[DATA_W-1] != opa_q[DATA_W-1]);
        end
    end

    assign RespOvf = ovf_q;
`endif

    assign RespId    = id_q;
    assign RespSum   = sum_q;
    assign RespCarry = carry_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Scoreboard bench for adder_share_ctrl: round-robin grant model plus queued sum checks.
module tb_adder_share_ctrl;

    localparam int unsigned N   = 4;
    localparam int unsigned S   = 2;
    localparam int unsigned IDW = 2;

    logic            Clock;
    logic            Reset;
    logic [N-1:0]    ReqValid;
    logic [N-1:0]    ReqReady;
    logic [32*N-1:0] ReqDataA;
    logic [32*N-1:0] ReqDataB;
    logic            RespValid;
    logic            RespReady;
    logic [IDW-1:0]  RespId;
    logic [31:0]     RespSum;
    logic            RespCarry;
`ifdef ADDER_SHARE_OVF_EN
    logic            RespOvf;
`endif

    logic [31:0] a_arr [N];
    logic [31:0] b_arr [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign ReqDataA[gi*32 +: 32] = a_arr[gi];
        assign ReqDataB[gi*32 +: 32] = b_arr[gi];
    end

    adder_share_ctrl #(.NUM_REQ(N), .SETTLE_CYCLES(S)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .ReqDataA  (ReqDataA),
        .ReqDataB  (ReqDataB),
        .RespValid (RespValid),
        .RespReady (RespReady),
        .RespId    (RespId),
        .RespSum   (RespSum),
        .RespCarry (RespCarry)
`ifdef ADDER_SHARE_OVF_EN
        ,
        .RespOvf   (RespOvf)
`endif
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    sum;
        logic           carry;
        logic           ovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference result: unsigned 33-bit sum, signed overflow from operand/result signs.
    function automatic exp_t ref_add(input int unsigned id, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [32:0] full;
        full    = {1'b0, a} + {1'b0, b};
        e.id    = IDW'(id);
        e.sum   = full[31:0];
        e.carry = full[32];
        e.ovf   = (a[31] == b[31]) && (full[31] != a[31]);
        return e;
    endfunction

    // Transaction-level model: busy from grant until the response handshake.
    bit          m_busy    = 1'b0;
    int unsigned m_ptr     = 0;
    int unsigned m_id      = 0;
    int          m_resp_at = 0;
    bit          rst_seen  = 1'b0;

    always @(negedge Clock) begin
        logic [N-1:0] exp_g;
        bit           exp_rv;
        int unsigned  sel;
        exp_g = '0;
        sel   = 0;
        if (Reset) begin
            chk("rst_req_ready", 64'(ReqReady), 64'(0));
            if (rst_seen) begin
                chk("rst_resp_valid", 64'(RespValid), 64'(0));
                chk("rst_resp_sum",   64'(RespSum),   64'(0));
                chk("rst_resp_id",    64'(RespId),    64'(0));
                chk("rst_resp_carry", 64'(RespCarry), 64'(0));
            end
            m_busy   = 1'b0;
            m_ptr    = 0;
            rst_seen = 1'b1;
            sb.delete();
        end else begin
            rst_seen = 1'b0;
            exp_rv   = m_busy && (cyc >= m_resp_at);
            chk("resp_valid", 64'(RespValid), 64'(exp_rv));
            if (!m_busy) begin
                for (int unsigned k = 0; k < N; k++) begin
                    sel = (m_ptr + k) % N;
                    if (ReqValid[IDW'(sel)]) begin
                        exp_g = N'(1) << sel;
                        break;
                    end
                end
            end
            chk("req_ready", 64'(ReqReady), 64'(exp_g));
            if (exp_g != '0) begin
                sb.push_back(ref_add(sel, a_arr[IDW'(sel)], b_arr[IDW'(sel)]));
                m_busy    = 1'b1;
                m_id      = sel;
                m_resp_at = cyc + int'(S) + 1;
            end else if (exp_rv && RespReady) begin
                m_busy = 1'b0;
                m_ptr  = (m_id + 1) % N;
            end
        end
    end

    // Monitor: every presented response must match the queue head, held until accepted.
    always @(negedge Clock) begin
        exp_t e;
        if (!Reset && RespValid === 1'b1) begin
            chk("resp_expected", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                e = sb[0];
                chk("resp_id",    64'(RespId),    64'(e.id));
                chk("resp_sum",   64'(RespSum),   64'(e.sum));
                chk("resp_carry", 64'(RespCarry), 64'(e.carry));
`ifdef ADDER_SHARE_OVF_EN
                chk("resp_ovf",   64'(RespOvf),   64'(e.ovf));
`endif
                if (RespReady) void'(sb.pop_front());
            end
        end
    end

    function automatic logic [31:0] rnd_data();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic tick(output logic [N-1:0] g);
        @(negedge Clock);
        #1;
        g = ReqReady;
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input int n);
        logic [N-1:0] g;
        for (int i = 0; i < n; i++) tick(g);
    endtask

    // Wait (bounded) for requester idx to be granted, then withdraw its request.
    task automatic wait_grant(input int unsigned idx);
        logic [N-1:0] g;
        bit           got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick(g);
            if (g[IDW'(idx)]) begin
                got                 = 1'b1;
                ReqValid[IDW'(idx)] = 1'b0;
            end
        end
        chk("grant_within_bound", 64'(got), 64'(1));
    endtask

    task automatic apply_reset(input int n);
        Reset = 1'b1;
        idle(n);
        Reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] g;
        Reset     = 1'b1;
        ReqValid  = '1;
        RespReady = 1'b0;
        for (int i = 0; i < N; i++) begin
            a_arr[i] = 32'($urandom);
            b_arr[i] = 32'($urandom);
        end
        idle(3);
        ReqValid = '0;
        Reset    = 1'b0;
        idle(2);

        // Carry-out wrap on requester 0.
        a_arr[0]  = 32'hFFFF_FFFF;
        b_arr[0]  = 32'h0000_0001;
        RespReady = 1'b1;
        ReqValid  = 4'b0001;
        wait_grant(0);
        idle(6);

        // All requesters held high: rotation 0,1,2,3,0 from a fresh pointer.
        apply_reset(2);
        for (int i = 0; i < N; i++) begin
            a_arr[i] = 32'(i);
            b_arr[i] = 32'h10;
        end
        ReqValid = '1;
        idle(5 * (S + 2) + 1);
        ReqValid = '0;
        idle(6);

        // Back-pressure on requester 2 with requester 1 pending.
        a_arr[2]  = 32'h1234_5678;
        b_arr[2]  = 32'h1111_1111;
        RespReady = 1'b0;
        ReqValid  = 4'b0100;
        wait_grant(2);
        a_arr[1]    = rnd_data();
        b_arr[1]    = rnd_data();
        ReqValid[1] = 1'b1;
        idle(S + 6);
        RespReady = 1'b1;
        wait_grant(1);
        idle(6);

        // Reset in the second settle cycle discards requester 3's operation.
        a_arr[3] = 32'hDEAD_BEEF;
        b_arr[3] = 32'h0101_0101;
        ReqValid = 4'b1000;
        wait_grant(3);
        tick(g);
        apply_reset(2);
        a_arr[1] = 32'h0000_0005;
        b_arr[1] = 32'h0000_0007;
        ReqValid = 4'b1010;
        wait_grant(1);
        wait_grant(3);
        idle(6);

        // Signed-overflow corner operands.
        a_arr[0] = 32'h7FFF_FFFF;
        b_arr[0] = 32'h0000_0001;
        a_arr[2] = 32'h8000_0000;
        b_arr[2] = 32'h8000_0000;
        ReqValid = 4'b0101;
        wait_grant(0);
        wait_grant(2);
        idle(6);

        // Randomised traffic with withdrawals, re-requests, stalls and rare resets.
        for (int n = 0; n < 1500; n++) begin
            tick(g);
            Reset = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (g[IDW'(i)]) begin
                    if ($urandom_range(0, 2) != 0) ReqValid[IDW'(i)] = 1'b0;
                end else if (ReqValid[IDW'(i)]) begin
                    if ($urandom_range(0, 15) == 0) ReqValid[IDW'(i)] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    a_arr[i]            = rnd_data();
                    b_arr[i]            = rnd_data();
                    ReqValid[IDW'(i)]   = 1'b1;
                end
            end
            RespReady = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) Reset = 1'b1;
        end

        Reset     = 1'b0;
        ReqValid  = '0;
        RespReady = 1'b1;
        idle(20);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
